alu_rs_multi: RTL and testbench

Parametrised multi-entry ALU reservation station, the successor to the single-entry station. It holds up to ENTRIES pending ALU operations and snoops the common data bus (CDB) for missing operands. Ready entries execute in a small internal ALU and compete for a one-deep result register, which is presented on the CDB through a request/accept handshake. It sits between the dispatch/rename logic and the shared CDB arbiter.

---
 rtl/alu_rs_pkg.sv | 27 ++
 rtl/alu_rs_rr_pick.sv | 47 ++++
 rtl/alu_rs_multi.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_rs_multi.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_pkg
//  Description : Shared definitions for the multi-entry ALU reservation
//                station: opcode encodings and operand-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

    // Opcode encodings carried on disp_op (low two bits are decoded).
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    // Number of opcode bits the ALU actually decodes.
    localparam int unsigned c_alu_op_bits = 2;

    // Operand fields must hold either a data word or a producer tag.
    function automatic int unsigned opnd_width(int unsigned data_w, int unsigned tag_w);
        return (data_w > tag_w) ? data_w : tag_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_rr_pick
//  Description : Round-robin priority picker. Scans the request mask starting
//                at ptr_i and wrapping, grants the first set bit.
//  Ports       : req_i   - request mask, one bit per slot
//                ptr_i   - index with highest priority this cycle
//                grant_o - one-hot grant (all zero when nothing requested)
//                valid_o - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_rr_pick
    import alu_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic [ENTRIES-1:0]         req_i,
    input  logic [$clog2(ENTRIES)-1:0] ptr_i,
    output logic [ENTRIES-1:0]         grant_o,
    output logic                       valid_o
);

    localparam int unsigned c_ptr_w = $clog2(ENTRIES);

    logic [c_ptr_w:0] w_idx;
    logic             w_found;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < ENTRIES; off++) begin
            // ptr + offset folded back into 0..ENTRIES-1 (works for non-pow2)
            w_idx = {1'b0, ptr_i} + (c_ptr_w + 1)'(off);
            if (w_idx >= (c_ptr_w + 1)'(ENTRIES)) begin
                w_idx = w_idx - (c_ptr_w + 1)'(ENTRIES);
            end
            if (!w_found && req_i[w_idx[c_ptr_w-1:0]]) begin
                grant_o[w_idx[c_ptr_w-1:0]] = 1'b1;
                w_found = 1'b1;
            end
        end
        valid_o = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/alu_rs_multi.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_multi
//  Description : Multi-entry ALU reservation station. Holds up to ENTRIES
//                pending operations, snoops the CDB for missing operands,
//                issues ready slots round-robin into a one-deep result
//                register presented on the CDB via request/accept.
//  Options     : ALU_RS_DISPATCH_BYPASS_EN - when defined, an operand being
//                dispatched as a tag that matches the same-cycle CDB
//                broadcast is captured as data immediately.
//  Ports       : disp_*        - dispatch request and operands
//                cdb_in_*      - snooped CDB broadcast
//                cdb_out_*     - result request/accept handshake
//                occupancy     - registered count of busy slots
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_multi
    import alu_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           disp_valid,
    output logic                                           disp_ready,
    input  logic [OP_W-1:0]                                disp_op,
    input  logic [TAG_W-1:0]                               disp_dest_tag,
    input  logic                                           disp_a_valid,
    input  logic [((DATA_W > TAG_W) ? DATA_W : TAG_W)-1:0] disp_a,
    input  logic                                           disp_b_valid,
    input  logic [((DATA_W > TAG_W) ? DATA_W : TAG_W)-1:0] disp_b,
    input  logic                                           cdb_in_valid,
    input  logic [TAG_W-1:0]                               cdb_in_tag,
    input  logic [DATA_W-1:0]                              cdb_in_data,
    output logic                                           cdb_out_request,
    output logic [TAG_W-1:0]                               cdb_out_tag,
    output logic [DATA_W-1:0]                              cdb_out_data,
    input  logic                                           cdb_out_accepted,
    output logic [$clog2(ENTRIES+1)-1:0]                   occupancy
);

    localparam int unsigned c_opnd_w = opnd_width(DATA_W, TAG_W);
    localparam int unsigned c_ptr_w  = $clog2(ENTRIES);
    localparam int unsigned c_occ_w  = $clog2(ENTRIES + 1);

    // An operand field holds data when its valid bit is set, otherwise the
    // producer tag in its low TAG_W bits.
    typedef struct packed {
        logic                busy;
        logic [OP_W-1:0]     op;
        logic                a_valid;
        logic [c_opnd_w-1:0] a;
        logic                b_valid;
        logic [c_opnd_w-1:0] b;
        logic [TAG_W-1:0]    dest_tag;
    } rs_entry_t;

    rs_entry_t           ent_q [ENTRIES];
    rs_entry_t           ent_d [ENTRIES];
    logic [c_ptr_w-1:0]  ptr_q, ptr_d;
    logic                res_valid_q, res_valid_d;
    logic [TAG_W-1:0]    res_tag_q, res_tag_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [c_occ_w-1:0]  occ_q, occ_d;

    logic [ENTRIES-1:0]  w_busy;
    logic [ENTRIES-1:0]  w_ready;
    logic [ENTRIES-1:0]  w_grant;
    logic [ENTRIES-1:0]  w_free_oh;
    logic                w_free_found;
    logic                w_pick_valid;
    logic                w_issue;
    logic                w_dispatch;
    logic [c_ptr_w-1:0]  w_sel_idx;
    logic [OP_W-1:0]     w_sel_op;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [TAG_W-1:0]    w_sel_tag;
    logic [DATA_W-1:0]   w_alu_res;
    rs_entry_t           w_new_ent;

    // ------------------------------------------------------------------
    // Slot status: IDLE (!busy), WAITING (busy, operand pending),
    // READY (busy, both operands valid).
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_status
        assign w_busy[gi]  = ent_q[gi].busy;
        assign w_ready[gi] = ent_q[gi].busy & ent_q[gi].a_valid & ent_q[gi].b_valid;
    end

    alu_rs_rr_pick #(
        .ENTRIES (ENTRIES)
    ) u_pick (
        .req_i   (w_ready),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .valid_o (w_pick_valid)
    );

    // Issue when the result register is empty or being drained this cycle.
    assign w_issue    = w_pick_valid & (~res_valid_q | cdb_out_accepted);
    // Start-of-cycle busy bits: a slot freed by issue is not reusable yet.
    assign disp_ready = ~(&w_busy);
    assign w_dispatch = disp_valid & disp_ready;

    // Lowest-index free slot.
    always_comb begin
        w_free_oh    = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_busy[i] && !w_free_found) begin
                w_free_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    // Fields of the granted slot.
    always_comb begin
        w_sel_idx = '0;
        w_sel_op  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_tag = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = c_ptr_w'(i);
                w_sel_op  = ent_q[i].op;
                w_sel_a   = ent_q[i].a[DATA_W-1:0];
                w_sel_b   = ent_q[i].b[DATA_W-1:0];
                w_sel_tag = ent_q[i].dest_tag;
            end
        end
    end

    // ALU: modulo 2^DATA_W, no flags.
    always_comb begin
        w_alu_res = '0;
        case (alu_op_e'(w_sel_op[c_alu_op_bits-1:0]))
            ALU_ADD: w_alu_res = w_sel_a + w_sel_b;
            ALU_SUB: w_alu_res = w_sel_a - w_sel_b;
            ALU_AND: w_alu_res = w_sel_a & w_sel_b;
            ALU_XOR: w_alu_res = w_sel_a ^ w_sel_b;
            default: w_alu_res = '0;
        endcase
    end

    // Entry written on dispatch.
    always_comb begin
        w_new_ent          = '0;
        w_new_ent.busy     = 1'b1;
        w_new_ent.op       = disp_op;
        w_new_ent.a_valid  = disp_a_valid;
        w_new_ent.a        = disp_a;
        w_new_ent.b_valid  = disp_b_valid;
        w_new_ent.b        = disp_b;
        w_new_ent.dest_tag = disp_dest_tag;
`ifdef ALU_RS_DISPATCH_BYPASS_EN
        // Catch a wakeup that arrives in the very cycle of dispatch.
        if (!disp_a_valid && cdb_in_valid && (disp_a[TAG_W-1:0] == cdb_in_tag)) begin
            w_new_ent.a_valid = 1'b1;
            w_new_ent.a       = c_opnd_w'(cdb_in_data);
        end
        if (!disp_b_valid && cdb_in_valid && (disp_b[TAG_W-1:0] == cdb_in_tag)) begin
            w_new_ent.b_valid = 1'b1;
            w_new_ent.b       = c_opnd_w'(cdb_in_data);
        end
`endif
    end

    // Slot next state: snoop, free on issue, fill on dispatch.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && cdb_in_valid) begin
                if (!ent_q[i].a_valid && (ent_q[i].a[TAG_W-1:0] == cdb_in_tag)) begin
                    ent_d[i].a_valid = 1'b1;
                    ent_d[i].a       = c_opnd_w'(cdb_in_data);
                end
                if (!ent_q[i].b_valid && (ent_q[i].b[TAG_W-1:0] == cdb_in_tag)) begin
                    ent_d[i].b_valid = 1'b1;
                    ent_d[i].b       = c_opnd_w'(cdb_in_data);
                end
            end
            if (w_issue && w_grant[i]) begin
                ent_d[i].busy = 1'b0;
            end
            if (w_dispatch && w_free_oh[i]) begin
                ent_d[i] = w_new_ent;
            end
        end
    end

    // Result register and round-robin pointer.
    always_comb begin
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        ptr_d       = ptr_q;
        if (w_issue) begin
            res_valid_d = 1'b1;
            res_tag_d   = w_sel_tag;
            res_data_d  = w_alu_res;
            ptr_d       = (w_sel_idx == c_ptr_w'(ENTRIES - 1)) ? '0 : w_sel_idx + c_ptr_w'(1);
        end else if (res_valid_q && cdb_out_accepted) begin
            res_valid_d = 1'b0;
        end
    end

    // Occupancy tracks the busy bits being registered this cycle.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_d = occ_d + c_occ_w'(ent_d[i].busy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            occ_q       <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            occ_q       <= occ_d;
        end
    end

    assign cdb_out_request = res_valid_q;
    assign cdb_out_tag     = res_tag_q;
    assign cdb_out_data    = res_data_q;
    assign occupancy       = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rs_multi
//  Description : Self-checking bench for alu_rs_multi (ENTRIES=4, 4-bit data
//                and tags). Directed scenarios followed by random traffic,
//                all compared against a slot-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs_multi;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned TW  = 4;
    localparam int unsigned OW  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned OCW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           disp_valid;
    logic           disp_ready;
    logic [OW-1:0]  disp_op;
    logic [TW-1:0]  disp_dest_tag;
    logic           disp_a_valid;
    logic [AW-1:0]  disp_a;
    logic           disp_b_valid;
    logic [AW-1:0]  disp_b;
    logic           cdb_in_valid;
    logic [TW-1:0]  cdb_in_tag;
    logic [DW-1:0]  cdb_in_data;
    logic           cdb_out_request;
    logic [TW-1:0]  cdb_out_tag;
    logic [DW-1:0]  cdb_out_data;
    logic           cdb_out_accepted;
    logic [OCW-1:0] occupancy;

    always #5 clk = ~clk;

    alu_rs_multi #(
        .ENTRIES (N),
        .DATA_W  (DW),
        .TAG_W   (TW),
        .OP_W    (OW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_op          (disp_op),
        .disp_dest_tag    (disp_dest_tag),
        .disp_a_valid     (disp_a_valid),
        .disp_a           (disp_a),
        .disp_b_valid     (disp_b_valid),
        .disp_b           (disp_b),
        .cdb_in_valid     (cdb_in_valid),
        .cdb_in_tag       (cdb_in_tag),
        .cdb_in_data      (cdb_in_data),
        .cdb_out_request  (cdb_out_request),
        .cdb_out_tag      (cdb_out_tag),
        .cdb_out_data     (cdb_out_data),
        .cdb_out_accepted (cdb_out_accepted),
        .occupancy        (occupancy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slots as plain arrays, result as a valid/tag/data triple.
    bit          m_busy [N];
    bit          m_av   [N];
    bit          m_bv   [N];
    int unsigned m_op   [N];
    int unsigned m_a    [N];
    int unsigned m_b    [N];
    int unsigned m_dt   [N];
    int unsigned m_ptr;
    bit          m_rv;
    int unsigned m_rt;
    int unsigned m_rd;

    function automatic int unsigned alu_ref(int unsigned op, int unsigned a, int unsigned b);
        int unsigned mask;
        mask = (32'd1 << DW) - 32'd1;
        case (op)
            0:       return (a + b) & mask;
            1:       return (a - b) & mask;
            2:       return (a & b) & mask;
            default: return (a ^ b) & mask;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        int pick;
        int fr;
        int unsigned idx;
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_ptr = 0; m_rv = 1'b0; m_rt = 0; m_rd = 0;
            return;
        end
        pick = -1;
        if (!m_rv || cdb_out_accepted) begin
            for (int off = 0; off < N; off++) begin
                idx = (m_ptr + off) % N;
                if (pick < 0 && m_busy[idx] && m_av[idx] && m_bv[idx]) pick = int'(idx);
            end
        end
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && cdb_in_valid) begin
                if (!m_av[i] && m_a[i] == cdb_in_tag) begin m_av[i] = 1'b1; m_a[i] = cdb_in_data; end
                if (!m_bv[i] && m_b[i] == cdb_in_tag) begin m_bv[i] = 1'b1; m_b[i] = cdb_in_data; end
            end
        end
        if (pick >= 0) begin
            m_rv = 1'b1;
            m_rt = m_dt[pick];
            m_rd = alu_ref(m_op[pick], m_a[pick], m_b[pick]);
            m_busy[pick] = 1'b0;
            m_ptr = (pick + 1) % N;
        end else if (m_rv && cdb_out_accepted) begin
            m_rv = 1'b0;
        end
        if (disp_valid && fr >= 0) begin
            m_busy[fr] = 1'b1;
            m_op[fr]   = disp_op;
            m_dt[fr]   = disp_dest_tag;
            m_av[fr]   = disp_a_valid;
            m_a[fr]    = disp_a;
            m_bv[fr]   = disp_b_valid;
            m_b[fr]    = disp_b;
`ifdef ALU_RS_DISPATCH_BYPASS_EN
            if (!disp_a_valid && cdb_in_valid && disp_a == cdb_in_tag) begin m_av[fr] = 1'b1; m_a[fr] = cdb_in_data; end
            if (!disp_b_valid && cdb_in_valid && disp_b == cdb_in_tag) begin m_bv[fr] = 1'b1; m_b[fr] = cdb_in_data; end
`endif
        end
    endtask

    task automatic check_all();
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += m_busy[i];
        chk("request", 32'(cdb_out_request), 32'(m_rv));
        if (m_rv) begin
            chk("tag", 32'(cdb_out_tag), m_rt);
            chk("data", 32'(cdb_out_data), m_rd);
        end
        chk("occupancy", 32'(occupancy), cnt);
        chk("disp_ready", 32'(disp_ready), (cnt < N) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        disp_valid       = 1'b0;
        cdb_in_valid     = 1'b0;
        cdb_out_accepted = 1'b0;
    endtask

    task automatic disp(input int unsigned op, input int unsigned dt,
                        input bit av, input int unsigned a,
                        input bit bv, input int unsigned b);
        disp_valid    = 1'b1;
        disp_op       = OW'(op);
        disp_dest_tag = TW'(dt);
        disp_a_valid  = av;
        disp_a        = AW'(a);
        disp_b_valid  = bv;
        disp_b        = AW'(b);
    endtask

    task automatic bcast(input int unsigned tag, input int unsigned data);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = TW'(tag);
        cdb_in_data  = DW'(data);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_op = '0; disp_dest_tag = '0;
        disp_a_valid = 1'b0; disp_a = '0; disp_b_valid = 1'b0; disp_b = '0;
        cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
        cdb_out_accepted = 1'b0;
        #2;

        // Reset state
        do_reset();
        chk("rst_tag", 32'(cdb_out_tag), 32'd0);
        chk("rst_data", 32'(cdb_out_data), 32'd0);
        chk("rst_ready", 32'(disp_ready), 32'd1);

        // Single ADD 3+4 -> tag 5 data 7, held while not accepted
        disp(0, 5, 1, 3, 1, 4);
        step();
        set_idle();
        step();
        chk("add_req", 32'(cdb_out_request), 32'd1);
        chk("add_tag", 32'(cdb_out_tag), 32'h5);
        chk("add_data", 32'(cdb_out_data), 32'h7);
        for (int k = 0; k < 3; k++) step();
        chk("add_hold", 32'(cdb_out_data), 32'h7);
        cdb_out_accepted = 1'b1;
        step();
        cdb_out_accepted = 1'b0;
        chk("add_drop", 32'(cdb_out_request), 32'd0);

        // SUB with pending A woken by broadcast: 1 - 2 wraps to 0xF
        disp(1, 1, 0, 9, 1, 2);
        step();
        set_idle();
        bcast(9, 1);
        step();
        set_idle();
        step();
        chk("sub_tag", 32'(cdb_out_tag), 32'h1);
        chk("sub_data", 32'(cdb_out_data), 32'hF);
        cdb_out_accepted = 1'b1;
        step();

        // Fill all slots, reject a fifth, then drain in order 0..3
        do_reset();
        disp(0, 4, 0, 10, 1, 1); step();
        disp(1, 5, 0, 10, 1, 1); step();
        disp(2, 6, 0, 10, 1, 3); step();
        disp(3, 7, 0, 10, 1, 3); step();
        chk("full_ready", 32'(disp_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        disp(0, 8, 1, 1, 1, 1); step();
        chk("fifth_ignored", 32'(occupancy), 32'd4);
        set_idle();
        cdb_out_accepted = 1'b1;
        bcast(10, 5);
        step();
        cdb_in_valid = 1'b0;
        step(); chk("rr0_tag", 32'(cdb_out_tag), 32'h4); chk("rr0_data", 32'(cdb_out_data), 32'h6);
        step(); chk("rr1_tag", 32'(cdb_out_tag), 32'h5); chk("rr1_data", 32'(cdb_out_data), 32'h4);
        step(); chk("rr2_tag", 32'(cdb_out_tag), 32'h6); chk("rr2_data", 32'(cdb_out_data), 32'h1);
        step(); chk("rr3_tag", 32'(cdb_out_tag), 32'h7); chk("rr3_data", 32'(cdb_out_data), 32'h6);
        step(); chk("rr_empty", 32'(cdb_out_request), 32'd0);
        set_idle();

        // Accept and new issue in the same cycle: no bubble
        disp(0, 8, 1, 1, 1, 1); step();
        disp(0, 9, 1, 2, 1, 2); step();
        set_idle();
        chk("b2b_first", 32'(cdb_out_tag), 32'h8);
        cdb_out_accepted = 1'b1;
        step();
        chk("b2b_req", 32'(cdb_out_request), 32'd1);
        chk("b2b_tag", 32'(cdb_out_tag), 32'h9);
        chk("b2b_data", 32'(cdb_out_data), 32'h4);
        step();
        cdb_out_accepted = 1'b0;

        // Reset mid-operation drops result and slots; later wakeup does nothing
        disp(0, 2, 1, 1, 1, 1);  step();
        disp(0, 3, 0, 11, 1, 1); step();
        disp(1, 4, 0, 11, 1, 1); step();
        disp(2, 5, 0, 11, 1, 1); step();
        set_idle();
        chk("pre_rst_req", 32'(cdb_out_request), 32'd1);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        do_reset();
        chk("mid_rst_req", 32'(cdb_out_request), 32'd0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        bcast(11, 3); step();
        set_idle(); step(); step();
        chk("post_rst_req", 32'(cdb_out_request), 32'd0);

`ifdef ALU_RS_DISPATCH_BYPASS_EN
        // Same-cycle dispatch/broadcast captured at dispatch
        do_reset();
        disp(0, 14, 0, 3, 1, 1);
        bcast(3, 6);
        step();
        set_idle();
        step();
        chk("bypass_req", 32'(cdb_out_request), 32'd1);
        chk("bypass_tag", 32'(cdb_out_tag), 32'hE);
        chk("bypass_data", 32'(cdb_out_data), 32'h7);
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst              = ($urandom_range(63) == 0);
            disp_valid       = 1'($urandom_range(1));
            disp_op          = OW'($urandom_range(3));
            disp_dest_tag    = TW'($urandom_range(15));
            disp_a_valid     = 1'($urandom_range(1));
            disp_a           = AW'(disp_a_valid ? $urandom_range(15) : $urandom_range(3));
            disp_b_valid     = 1'($urandom_range(1));
            disp_b           = AW'(disp_b_valid ? $urandom_range(15) : $urandom_range(3));
            cdb_in_valid     = 1'($urandom_range(1));
            cdb_in_tag       = TW'($urandom_range(3));
            cdb_in_data      = DW'($urandom_range(15));
            cdb_out_accepted = 1'($urandom_range(1));
            step();
        end
        rst = 1'b0;
        set_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
